// File: rtl/match_game_if.sv
// Signal bundle between the memory-match controller, the cursor/button front end
// and the board RAM that feeds the renderer.
interface match_game_if #(
    parameter int LOC_W  = 4,
    parameter int DATA_W = 6,
    parameter int SEED_W = 8
);
    logic              Start;
    logic              Select;
    logic [LOC_W-1:0]  CardSelectLoc;
    logic [DATA_W-1:0] CardSelectData;
    logic              Ack;
    logic [SEED_W-1:0] seed;
    logic [9:0]        state;
    logic              WriteEnable;
    logic [DATA_W-1:0] dataOut;
    logic [LOC_W-1:0]  dataLoc;
    logic [LOC_W-1:0]  numMatches;
    logic [7:0]        numMisses;
    logic              Win;
    logic              GameOver;

    modport master (
        output Start, Select, CardSelectLoc, CardSelectData, Ack, seed,
        input  state, WriteEnable, dataOut, dataLoc, numMatches, numMisses, Win, GameOver
    );

    modport slave (
        input  Start, Select, CardSelectLoc, CardSelectData, Ack, seed,
        output state, WriteEnable, dataOut, dataLoc, numMatches, numMisses, Win, GameOver
    );
endinterface

// File: rtl/match_game_fsm.sv
// Memory-match gameplay controller: deals a masked permutation of card pairs into
// the board RAM, then runs the two-card select/compare/flip loop with scoring.
module match_game_fsm #(
    parameter int NUM_PAIRS  = 8,
    parameter int LOC_W      = 4,
    parameter int DATA_W     = 6,
    parameter int SEED_W     = 8,
    parameter int MAX_MISSES = 0
) (
    input  logic        Clk,
    input  logic        Reset,
    match_game_if.slave bus
);
    localparam int               SYM_W    = DATA_W - 2;
    localparam logic [LOC_W-1:0] LAST_IDX = LOC_W'(2 * NUM_PAIRS - 1);
    localparam logic [LOC_W-1:0] PAIRS_L  = LOC_W'(NUM_PAIRS);
    localparam logic [LOC_W-1:0] ONE_LOC  = {{(LOC_W-1){1'b0}}, 1'b1};
    localparam logic [8:0]       MISS_LIM = 9'(MAX_MISSES);
    localparam bit               LIMIT_ON = (MAX_MISSES != 0);

    typedef enum logic [9:0] {
        S_INIT    = 10'b00_0000_0001,
        S_DEAL    = 10'b00_0000_0010,
        S_WAIT1   = 10'b00_0000_0100,
        S_WAIT2   = 10'b00_0000_1000,
        S_COMPARE = 10'b00_0001_0000,
        S_MARK2   = 10'b00_0010_0000,
        S_HOLD    = 10'b00_0100_0000,
        S_FLIP1   = 10'b00_1000_0000,
        S_FLIP2   = 10'b01_0000_0000,
        S_DONE    = 10'b10_0000_0000
    } state_t;

    state_t            state_q,   state_d;
    logic [LOC_W-1:0]  mask_q,    mask_d;
    logic [LOC_W-1:0]  idx_q,     idx_d;
    logic [LOC_W-1:0]  loc1_q,    loc1_d;
    logic [LOC_W-1:0]  loc2_q,    loc2_d;
    logic [SYM_W-1:0]  sym1_q,    sym1_d;
    logic [SYM_W-1:0]  sym2_q,    sym2_d;
    logic              we_q,      we_d;
    logic [DATA_W-1:0] dout_q,    dout_d;
    logic [LOC_W-1:0]  dloc_q,    dloc_d;
    logic [LOC_W-1:0]  matches_q, matches_d;
    logic [7:0]        misses_q,  misses_d;
    logic              win_q,     win_d;
    logic              over_q,    over_d;

    logic              sel_free_s;
    logic [SYM_W-1:0]  sel_sym_s;
    logic [7:0]        miss_inc_s;
    logic              seed_unused_s;

    // A card can be picked only while it is neither matched nor already face-up.
    assign sel_free_s    = ~bus.CardSelectData[DATA_W-1] & ~bus.CardSelectData[DATA_W-2];
    assign sel_sym_s     = bus.CardSelectData[SYM_W-1:0];
    assign miss_inc_s    = (misses_q == 8'hFF) ? 8'hFF : (misses_q + 8'h01);
    assign seed_unused_s = ^bus.seed;

    // State and datapath registers, cleared asynchronously by the active-low reset.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= S_INIT;
            mask_q    <= {LOC_W{1'b0}};
            idx_q     <= {LOC_W{1'b0}};
            loc1_q    <= {LOC_W{1'b0}};
            loc2_q    <= {LOC_W{1'b0}};
            sym1_q    <= {SYM_W{1'b0}};
            sym2_q    <= {SYM_W{1'b0}};
            we_q      <= 1'b0;
            dout_q    <= {DATA_W{1'b0}};
            dloc_q    <= {LOC_W{1'b0}};
            matches_q <= {LOC_W{1'b0}};
            misses_q  <= 8'h00;
            win_q     <= 1'b0;
            over_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            idx_q     <= idx_d;
            loc1_q    <= loc1_d;
            loc2_q    <= loc2_d;
            sym1_q    <= sym1_d;
            sym2_q    <= sym2_d;
            we_q      <= we_d;
            dout_q    <= dout_d;
            dloc_q    <= dloc_d;
            matches_q <= matches_d;
            misses_q  <= misses_d;
            win_q     <= win_d;
            over_q    <= over_d;
        end
    end

    // Next-state, board-write and scoring decisions; writes land one cycle later.
    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        idx_d     = idx_q;
        loc1_d    = loc1_q;
        loc2_d    = loc2_q;
        sym1_d    = sym1_q;
        sym2_d    = sym2_q;
        we_d      = 1'b0;
        dout_d    = dout_q;
        dloc_d    = dloc_q;
        matches_d = matches_q;
        misses_d  = misses_q;
        win_d     = win_q;
        over_d    = over_q;

        case (state_q)
            S_INIT: begin
                if (bus.Start) begin
                    mask_d    = bus.seed[LOC_W-1:0] & LAST_IDX;
                    idx_d     = {LOC_W{1'b0}};
                    matches_d = {LOC_W{1'b0}};
                    misses_d  = 8'h00;
                    win_d     = 1'b0;
                    over_d    = 1'b0;
                    state_d   = S_DEAL;
                end else begin
                    state_d = S_INIT;
                end
            end
            S_DEAL: begin
                // Consecutive indices share a symbol; the mask scatters them.
                we_d   = 1'b1;
                dloc_d = idx_q ^ mask_q;
                dout_d = {2'b00, SYM_W'(idx_q >> 1'b1)};
                if (idx_q == LAST_IDX) begin
                    state_d = S_WAIT1;
                end else begin
                    idx_d   = idx_q + ONE_LOC;
                    state_d = S_DEAL;
                end
            end
            S_WAIT1: begin
                if (bus.Select && sel_free_s) begin
                    loc1_d  = bus.CardSelectLoc;
                    sym1_d  = sel_sym_s;
                    we_d    = 1'b1;
                    dloc_d  = bus.CardSelectLoc;
                    dout_d  = {2'b01, sel_sym_s};
                    state_d = S_WAIT2;
                end else begin
                    state_d = S_WAIT1;
                end
            end
            S_WAIT2: begin
                // loc1 is filtered explicitly: its face-up write may not have reached the RAM yet.
                if (bus.Select && sel_free_s && (bus.CardSelectLoc != loc1_q)) begin
                    loc2_d  = bus.CardSelectLoc;
                    sym2_d  = sel_sym_s;
                    we_d    = 1'b1;
                    dloc_d  = bus.CardSelectLoc;
                    dout_d  = {2'b01, sel_sym_s};
                    state_d = S_COMPARE;
                end else begin
                    state_d = S_WAIT2;
                end
            end
            S_COMPARE: begin
                if (sym1_q == sym2_q) begin
                    we_d      = 1'b1;
                    dloc_d    = loc1_q;
                    dout_d    = {2'b11, sym1_q};
                    matches_d = matches_q + ONE_LOC;
                    state_d   = S_MARK2;
                end else begin
                    state_d = S_HOLD;
                end
            end
            S_MARK2: begin
                we_d   = 1'b1;
                dloc_d = loc2_q;
                dout_d = {2'b11, sym2_q};
                if (matches_q == PAIRS_L) begin
                    win_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_WAIT1;
                end
            end
            S_HOLD: begin
                if (bus.Ack) begin
                    state_d = S_FLIP1;
                end else begin
                    state_d = S_HOLD;
                end
            end
            S_FLIP1: begin
                we_d    = 1'b1;
                dloc_d  = loc1_q;
                dout_d  = {2'b00, sym1_q};
                state_d = S_FLIP2;
            end
            S_FLIP2: begin
                we_d     = 1'b1;
                dloc_d   = loc2_q;
                dout_d   = {2'b00, sym2_q};
                misses_d = miss_inc_s;
                if (LIMIT_ON && ({1'b0, miss_inc_s} >= MISS_LIM)) begin
                    over_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_WAIT1;
                end
            end
            S_DONE: begin
                if (bus.Ack) begin
                    state_d = S_INIT;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    assign bus.state       = state_q;
    assign bus.WriteEnable = we_q;
    assign bus.dataOut     = dout_q;
    assign bus.dataLoc     = dloc_q;
    assign bus.numMatches  = matches_q;
    assign bus.numMisses   = misses_q;
    assign bus.Win         = win_q;
    assign bus.GameOver    = over_q;
endmodule

// File: tb/tb_match_game_fsm.sv
// Directed bench for match_game_fsm: two instances (unlimited misses and a limit
// of two) share stimulus, each backed by its own board RAM model.
module tb_match_game_fsm;
    localparam logic [9:0] ST_INIT  = 10'h001, ST_DEAL  = 10'h002, ST_WAIT1 = 10'h004;
    localparam logic [9:0] ST_WAIT2 = 10'h008, ST_CMP   = 10'h010, ST_MARK2 = 10'h020;
    localparam logic [9:0] ST_HOLD  = 10'h040, ST_FLIP1 = 10'h080, ST_FLIP2 = 10'h100;
    localparam logic [9:0] ST_DONE  = 10'h200;

    logic       Clk;
    logic       Reset;
    logic       start_s, select_s, ack_s;
    logic [3:0] loc_s;
    logic [7:0] seed_s;
    logic [5:0] ram_a [16];
    logic [5:0] ram_b [16];
    int         checks = 0;
    int         errors = 0;

    match_game_if #(.LOC_W(4), .DATA_W(6), .SEED_W(8)) ifa ();
    match_game_if #(.LOC_W(4), .DATA_W(6), .SEED_W(8)) ifb ();

    assign ifa.Start = start_s;  assign ifa.Select = select_s;  assign ifa.Ack = ack_s;
    assign ifa.CardSelectLoc = loc_s;  assign ifa.seed = seed_s;
    assign ifa.CardSelectData = ram_a[ifa.CardSelectLoc];
    assign ifb.Start = start_s;  assign ifb.Select = select_s;  assign ifb.Ack = ack_s;
    assign ifb.CardSelectLoc = loc_s;  assign ifb.seed = seed_s;
    assign ifb.CardSelectData = ram_b[ifb.CardSelectLoc];

    match_game_fsm #(.NUM_PAIRS(8), .LOC_W(4), .DATA_W(6), .SEED_W(8), .MAX_MISSES(0))
        dut_a (.Clk(Clk), .Reset(Reset), .bus(ifa));
    match_game_fsm #(.NUM_PAIRS(8), .LOC_W(4), .DATA_W(6), .SEED_W(8), .MAX_MISSES(2))
        dut_b (.Clk(Clk), .Reset(Reset), .bus(ifb));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Board RAM models: synchronous write, combinational read.
    always @(posedge Clk) begin
        if (ifa.WriteEnable) ram_a[ifa.dataLoc] <= ifa.dataOut;
        if (ifb.WriteEnable) ram_b[ifb.dataLoc] <= ifb.dataOut;
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic pick(input logic [3:0] l);
        loc_s = l; select_s = 1'b1;
        step();
        select_s = 1'b0;
    endtask

    task automatic start_game(input logic [7:0] s);
        int n;
        Reset = 1'b0; #3; Reset = 1'b1;
        seed_s = s; start_s = 1'b1;
        step();
        start_s = 1'b0;
        n = 0;
        while (ifa.state !== ST_WAIT1 && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (ifa.state !== ST_WAIT1) begin
            errors++;
            $display("FAIL deal_timeout: state=%h want %h", ifa.state, ST_WAIT1);
        end
        step();
    endtask

    task automatic miss_pair(input logic [3:0] l1, input logic [3:0] l2);
        pick(l1); pick(l2); step();
        ack_s = 1'b1; step(); ack_s = 1'b0;
        step(); step();
    endtask

    task automatic test_reset();
        #50;
        checks++;
        if ({ifa.state, ifa.WriteEnable, ifa.dataOut, ifa.dataLoc, ifa.numMatches, ifa.numMisses, ifa.Win, ifa.GameOver}
            !== {ST_INIT, 1'b0, 6'h00, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_a: st=%h we=%b d=%h l=%h", ifa.state, ifa.WriteEnable, ifa.dataOut, ifa.dataLoc);
        end
        checks++;
        if ({ifb.state, ifb.WriteEnable, ifb.numMisses, ifb.GameOver} !== {ST_INIT, 1'b0, 8'h00, 1'b0}) begin
            errors++;
            $display("FAIL reset_b: st=%h we=%b miss=%0d", ifb.state, ifb.WriteEnable, ifb.numMisses);
        end
        #50;
        Reset = 1'b1;
    endtask

    task automatic test_deal_mask0();
        step();
        checks++;
        if ({ifa.state, ifa.WriteEnable} !== {ST_DEAL, 1'b0}) begin
            errors++;
            $display("FAIL deal_entry: st=%h we=%b want %h 0", ifa.state, ifa.WriteEnable, ST_DEAL);
        end
        start_s = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            checks++;
            if ({ifa.WriteEnable, ifa.dataLoc, ifa.dataOut} !== {1'b1, 4'(i), 6'(i / 2)}) begin
                errors++;
                $display("FAIL deal0[%0d]: we=%b loc=%0d data=%h want 1 %0d %h",
                         i, ifa.WriteEnable, ifa.dataLoc, ifa.dataOut, i, i / 2);
            end
        end
        checks++;
        if (ifa.state !== ST_WAIT1) begin
            errors++;
            $display("FAIL deal0_end_state: st=%h want %h", ifa.state, ST_WAIT1);
        end
        step();
        checks++;
        if ({ifa.state, ifa.WriteEnable} !== {ST_WAIT1, 1'b0}) begin
            errors++;
            $display("FAIL deal0_idle: st=%h we=%b", ifa.state, ifa.WriteEnable);
        end
    endtask

    task automatic test_match();
        logic [20:0] got [9];
        logic [20:0] exp [9];
        pick(4'd2);  got[0] = {ifa.WriteEnable, ifa.dataLoc, ifa.dataOut, ifa.state}; exp[0] = {1'b1, 4'd2, 6'h11, ST_WAIT2};
        pick(4'd3);  got[1] = {ifa.WriteEnable, ifa.dataLoc, ifa.dataOut, ifa.state}; exp[1] = {1'b1, 4'd3, 6'h11, ST_CMP};
        step();      got[2] = {ifa.WriteEnable, ifa.dataLoc, ifa.dataOut, ifa.state}; exp[2] = {1'b1, 4'd2, 6'h31, ST_MARK2};
        checks++;
        if (ifa.numMatches !== 4'd1) begin
            errors++;
            $display("FAIL match_count1: got %0d want 1", ifa.numMatches);
        end
        step();      got[3] = {ifa.WriteEnable, ifa.dataLoc, ifa.dataOut, ifa.state}; exp[3] = {1'b1, 4'd3, 6'h31, ST_WAIT1};
        pick(4'd2);  got[4] = {ifa.WriteEnable, 10'h000, ifa.state};                   exp[4] = {1'b0, 10'h000, ST_WAIT1};
        pick(4'd4);  got[5] = {ifa.WriteEnable, ifa.dataLoc, ifa.dataOut, ifa.state}; exp[5] = {1'b1, 4'd4, 6'h12, ST_WAIT2};
        pick(4'd4);  got[6] = {ifa.WriteEnable, 10'h000, ifa.state};                   exp[6] = {1'b0, 10'h000, ST_WAIT2};
        pick(4'd3);  got[7] = {ifa.WriteEnable, 10'h000, ifa.state};                   exp[7] = {1'b0, 10'h000, ST_WAIT2};
        pick(4'd5);  got[8] = {ifa.WriteEnable, ifa.dataLoc, ifa.dataOut, ifa.state}; exp[8] = {1'b1, 4'd5, 6'h12, ST_CMP};
        for (int k = 0; k < 9; k++) begin
            checks++;
            if (got[k] !== exp[k]) begin
                errors++;
                $display("FAIL match_step%0d: got %h want %h", k, got[k], exp[k]);
            end
        end
        step(); step();
        checks++;
        if ({ifa.numMatches, ifa.state} !== {4'd2, ST_WAIT1}) begin
            errors++;
            $display("FAIL match_count2: n=%0d st=%h want 2 %h", ifa.numMatches, ifa.state, ST_WAIT1);
        end
    endtask

    task automatic test_mismatch();
        start_game(8'h30);
        pick(4'd0);
        checks++;
        if ({ifa.WriteEnable, ifa.dataLoc, ifa.dataOut, ifa.state} !== {1'b1, 4'd0, 6'h10, ST_WAIT2}) begin
            errors++;
            $display("FAIL miss_sel1: we=%b l=%0d d=%h st=%h", ifa.WriteEnable, ifa.dataLoc, ifa.dataOut, ifa.state);
        end
        pick(4'd2);
        step();
        checks++;
        if ({ifa.WriteEnable, ifa.state} !== {1'b0, ST_HOLD}) begin
            errors++;
            $display("FAIL miss_hold: we=%b st=%h want 0 %h", ifa.WriteEnable, ifa.state, ST_HOLD);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if ({ifa.WriteEnable, ifa.state} !== {1'b0, ST_HOLD}) begin
                errors++;
                $display("FAIL miss_hold_wait%0d: we=%b st=%h", k, ifa.WriteEnable, ifa.state);
            end
        end
        ack_s = 1'b1; step(); ack_s = 1'b0;
        checks++;
        if ({ifa.WriteEnable, ifa.state} !== {1'b0, ST_FLIP1}) begin
            errors++;
            $display("FAIL miss_ack: we=%b st=%h want 0 %h", ifa.WriteEnable, ifa.state, ST_FLIP1);
        end
        step();
        checks++;
        if ({ifa.WriteEnable, ifa.dataLoc, ifa.dataOut, ifa.state} !== {1'b1, 4'd0, 6'h00, ST_FLIP2}) begin
            errors++;
            $display("FAIL miss_flip1: we=%b l=%0d d=%h st=%h", ifa.WriteEnable, ifa.dataLoc, ifa.dataOut, ifa.state);
        end
        step();
        checks++;
        if ({ifa.WriteEnable, ifa.dataLoc, ifa.dataOut, ifa.state, ifa.numMisses} !== {1'b1, 4'd2, 6'h01, ST_WAIT1, 8'd1}) begin
            errors++;
            $display("FAIL miss_flip2: we=%b l=%0d d=%h st=%h m=%0d",
                     ifa.WriteEnable, ifa.dataLoc, ifa.dataOut, ifa.state, ifa.numMisses);
        end
    endtask

    task automatic test_miss_limit();
        checks++;
        if ({ifb.state, ifb.numMisses, ifb.GameOver} !== {ST_WAIT1, 8'd1, 1'b0}) begin
            errors++;
            $display("FAIL limit_first: st=%h m=%0d go=%b", ifb.state, ifb.numMisses, ifb.GameOver);
        end
        miss_pair(4'd0, 4'd2);
        checks++;
        if ({ifb.state, ifb.GameOver, ifb.Win, ifb.numMisses} !== {ST_DONE, 1'b1, 1'b0, 8'd2}) begin
            errors++;
            $display("FAIL limit_done: st=%h go=%b win=%b m=%0d", ifb.state, ifb.GameOver, ifb.Win, ifb.numMisses);
        end
        checks++;
        if ({ifa.state, ifa.GameOver, ifa.numMisses} !== {ST_WAIT1, 1'b0, 8'd2}) begin
            errors++;
            $display("FAIL unlimited: st=%h go=%b m=%0d", ifa.state, ifa.GameOver, ifa.numMisses);
        end
        start_s = 1'b1; ack_s = 1'b1; step(); start_s = 1'b0; ack_s = 1'b0;
        step();
        checks++;
        if ({ifb.state, ifb.numMisses} !== {ST_INIT, 8'd2}) begin
            errors++;
            $display("FAIL limit_ack: st=%h m=%0d want %h 2", ifb.state, ifb.numMisses, ST_INIT);
        end
        checks++;
        if (ifa.state !== ST_WAIT1) begin
            errors++;
            $display("FAIL ack_ignored: st=%h want %h", ifa.state, ST_WAIT1);
        end
    endtask

    task automatic test_win_all();
        start_game(8'h30);
        for (int p = 0; p < 8; p++) begin
            pick(4'(2 * p)); pick(4'(2 * p + 1)); step(); step();
        end
        checks++;
        if ({ifa.state, ifa.Win, ifa.GameOver, ifa.numMatches} !== {ST_DONE, 1'b1, 1'b0, 4'd8}) begin
            errors++;
            $display("FAIL win: st=%h win=%b go=%b n=%0d", ifa.state, ifa.Win, ifa.GameOver, ifa.numMatches);
        end
        ack_s = 1'b1; step(); ack_s = 1'b0;
        checks++;
        if ({ifa.state, ifa.numMatches} !== {ST_INIT, 4'd8}) begin
            errors++;
            $display("FAIL win_ack: st=%h n=%0d want %h 8", ifa.state, ifa.numMatches, ST_INIT);
        end
    endtask

    task automatic test_deal_mask5();
        logic [3:0] exp_loc [4];
        exp_loc[0] = 4'd5; exp_loc[1] = 4'd4; exp_loc[2] = 4'd7; exp_loc[3] = 4'd6;
        seed_s = 8'h35; start_s = 1'b1; step(); start_s = 1'b0;
        checks++;
        if ({ifa.state, ifa.numMatches} !== {ST_DEAL, 4'd0}) begin
            errors++;
            $display("FAIL restart: st=%h n=%0d want %h 0", ifa.state, ifa.numMatches, ST_DEAL);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({ifa.WriteEnable, ifa.dataLoc, ifa.dataOut} !== {1'b1, exp_loc[i], 6'(i / 2)}) begin
                errors++;
                $display("FAIL deal5[%0d]: we=%b loc=%0d data=%h want loc %0d", i, ifa.WriteEnable, ifa.dataLoc, ifa.dataOut, exp_loc[i]);
            end
        end
        repeat (12) step();
        checks++;
        if ({ifa.WriteEnable, ifa.dataLoc, ifa.dataOut} !== {1'b1, 4'd10, 6'h07}) begin
            errors++;
            $display("FAIL deal5_last: we=%b loc=%0d data=%h want 1 10 07", ifa.WriteEnable, ifa.dataLoc, ifa.dataOut);
        end
    endtask

    task automatic test_reset_mid_deal();
        Reset = 1'b0; #3; Reset = 1'b1;
        seed_s = 8'h30; start_s = 1'b1; step(); start_s = 1'b0;
        repeat (7) step();
        checks++;
        if ({ifa.WriteEnable, ifa.dataLoc, ifa.dataOut} !== {1'b1, 4'd6, 6'h03}) begin
            errors++;
            $display("FAIL mid_deal_pre: we=%b loc=%0d data=%h", ifa.WriteEnable, ifa.dataLoc, ifa.dataOut);
        end
        #2 Reset = 1'b0;
        #1;
        checks++;
        if ({ifa.state, ifa.WriteEnable, ifa.dataLoc, ifa.dataOut} !== {ST_INIT, 1'b0, 4'd0, 6'h00}) begin
            errors++;
            $display("FAIL mid_deal_reset: st=%h we=%b loc=%0d data=%h", ifa.state, ifa.WriteEnable, ifa.dataLoc, ifa.dataOut);
        end
        Reset = 1'b1;
        step();
        checks++;
        if ({ifa.state, ifa.WriteEnable} !== {ST_INIT, 1'b0}) begin
            errors++;
            $display("FAIL post_reset: st=%h we=%b", ifa.state, ifa.WriteEnable);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b0; start_s = 1'b1; seed_s = 8'h30;
        select_s = 1'b0; ack_s = 1'b0; loc_s = 4'd0;
        test_reset();
        test_deal_mask0();
        test_match();
        test_mismatch();
        test_miss_limit();
        test_win_all();
        test_deal_mask5();
        test_reset_mid_deal();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
